// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: next-state logic, frame timer, key edges, HP and winner
// for the two-player artillery game.
//
// Ports:
//   Clk, Reset_n          game clock, async active-low reset
//   state[3:0]            current registered game state
//   frame_tick            one-cycle pulse per video frame
//   start_key, fire_key   key levels, synchronous to Clk
//   hit_p1, hit_p2        one-cycle projectile hit pulses
//   next_state[3:0]       combinational next state for the state register
//   frame_cnt[9:0]        frames elapsed in the current state
//   p1_hp, p2_hp[3:0]     remaining hit points
//   last_player           shooter of the most recent turn (0=P1, 1=P2)
//   winner[1:0]           0 none, 1 P1, 2 P2, 3 draw
module game_turn_ctrl #(
  parameter int TURN_FRAMES  = 600,
  parameter int SLEEP_FRAMES = 120,
  parameter int DOWN_FRAMES  = 60,
  parameter int MAX_HP       = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] state,
  input  logic       frame_tick,
  input  logic       start_key,
  input  logic       fire_key,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [3:0] next_state,
  output logic [9:0] frame_cnt,
  output logic [3:0] p1_hp,
  output logic [3:0] p2_hp,
  output logic       last_player,
  output logic [1:0] winner
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_P1TURN  = 4'h1,
    S_P2TURN  = 4'h2,
    S_SLEEP   = 4'h3,
    S_P1DOWN  = 4'h4,
    S_P2DOWN  = 4'h5,
    S_ENDGAME = 4'h6,
    S_MENU    = 4'hF
  } gstate_e;

  logic       r_start_q;
  logic       r_fire_q;
  logic [3:0] r_state_q;
  logic [9:0] r_cnt;
  logic [3:0] r_p1_hp;
  logic [3:0] r_p2_hp;
  logic       r_last;
  logic [1:0] r_winner;
  logic       r_pend1;
  logic       r_pend2;

  logic    w_start_rise;
  logic    w_fire_rise;
  logic    w_chg;
  logic    w_tick;
  logic    w_exp_turn;
  logic    w_exp_sleep;
  logic    w_exp_down;
  logic    w_in_turn;
  logic    w_hp_zero;
  logic    w_hit_ok;
  logic    w_go_game;
  logic    w_go_shot;
  logic    w_go_end;
  gstate_e w_other;

  assign w_start_rise = start_key & ~r_start_q;
  assign w_fire_rise  = fire_key  & ~r_fire_q;

  // A tick landing on a state change is dropped, so it cannot
  // expire a timer that still holds the previous state's count.
  assign w_chg  = (state != r_state_q);
  assign w_tick = frame_tick & ~w_chg;

  assign w_exp_turn  = w_tick & (r_cnt == 10'(TURN_FRAMES - 1));
  assign w_exp_sleep = w_tick & (r_cnt == 10'(SLEEP_FRAMES - 1));
  assign w_exp_down  = w_tick & (r_cnt == 10'(DOWN_FRAMES - 1));

  assign w_in_turn = (state == S_P1TURN) | (state == S_P2TURN);
  assign w_hp_zero = (r_p1_hp == 4'd0) | (r_p2_hp == 4'd0);
  assign w_hit_ok  = (state == S_SLEEP) & ~w_exp_sleep;
  assign w_other   = r_last ? S_P1TURN : S_P2TURN;

  assign w_go_game = (state == S_MENU) & w_start_rise;
  assign w_go_shot = w_in_turn & (w_fire_rise | w_exp_turn);
  assign w_go_end  = (state == S_SLEEP) & w_exp_sleep & w_hp_zero;

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:
        if (w_start_rise) next_state = S_MENU;
      S_MENU:
        if (w_start_rise) next_state = S_P1TURN;
      S_P1TURN,
      S_P2TURN:
        if (w_fire_rise | w_exp_turn) next_state = S_SLEEP;
      S_SLEEP:
        if (w_exp_sleep) begin
          if (w_hp_zero)    next_state = S_ENDGAME;
          else if (r_pend1) next_state = S_P1DOWN;
          else if (r_pend2) next_state = S_P2DOWN;
          else              next_state = w_other;
        end
      S_P1DOWN,
      S_P2DOWN:
        if (w_exp_down) next_state = w_other;
      S_ENDGAME:
        if (w_start_rise) next_state = S_IDLE;
      default:
        next_state = S_IDLE;
    endcase
  end

  // Key history resets high so a key held through reset is not an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_start_q <= 1'b1;
      r_fire_q  <= 1'b1;
      r_state_q <= S_IDLE;
    end else begin
      r_start_q <= start_key;
      r_fire_q  <= fire_key;
      r_state_q <= state;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (w_chg) begin
      r_cnt <= '0;
    end else if (frame_tick && r_cnt != 10'h3FF) begin
      r_cnt <= r_cnt + 10'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_p1_hp <= '0;
      r_p2_hp <= '0;
    end else if (w_go_game) begin
      r_p1_hp <= 4'(MAX_HP);
      r_p2_hp <= 4'(MAX_HP);
    end else if (w_hit_ok) begin
      if (hit_p1 && r_p1_hp != 4'd0)
        r_p1_hp <= r_p1_hp - 4'd1;
      if (hit_p2 && r_p2_hp != 4'd0)
        r_p2_hp <= r_p2_hp - 4'd1;
    end
  end

  // Pending hits survive only within one stay in a state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
    end else begin
      r_pend1 <= (r_pend1 & ~w_chg) | (w_hit_ok & hit_p1);
      r_pend2 <= (r_pend2 & ~w_chg) | (w_hit_ok & hit_p2);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last   <= 1'b0;
      r_winner <= 2'd0;
    end else begin
      if (w_go_game) begin
        r_last   <= 1'b0;
        r_winner <= 2'd0;
      end else if (w_go_shot) begin
        r_last <= (state == S_P2TURN);
      end else if (w_go_end) begin
        if (r_p1_hp == 4'd0 && r_p2_hp == 4'd0)
          r_winner <= 2'd3;
        else if (r_p1_hp != 4'd0)
          r_winner <= 2'd1;
        else
          r_winner <= 2'd2;
      end
    end
  end

  assign frame_cnt   = r_cnt;
  assign p1_hp       = r_p1_hp;
  assign p2_hp       = r_p2_hp;
  assign last_player = r_last;
  assign winner      = r_winner;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// tb_game_turn_ctrl: directed game walk plus random play against
// a behavioural model of the turn rules; the bench is the state register.
module tb_game_turn_ctrl;

  localparam int TF = 4;
  localparam int SF = 3;
  localparam int DF = 2;
  localparam int MH = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] state = 4'h0;
  logic       frame_tick = 1'b0;
  logic       start_key = 1'b0;
  logic       fire_key = 1'b0;
  logic       hit_p1 = 1'b0;
  logic       hit_p2 = 1'b0;
  logic [3:0] next_state;
  logic [9:0] frame_cnt;
  logic [3:0] p1_hp;
  logic [3:0] p2_hp;
  logic       last_player;
  logic [1:0] winner;

  game_turn_ctrl #(
    .TURN_FRAMES (TF),
    .SLEEP_FRAMES(SF),
    .DOWN_FRAMES (DF),
    .MAX_HP      (MH)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .state      (state),
    .frame_tick (frame_tick),
    .start_key  (start_key),
    .fire_key   (fire_key),
    .hit_p1     (hit_p1),
    .hit_p2     (hit_p2),
    .next_state (next_state),
    .frame_cnt  (frame_cnt),
    .p1_hp      (p1_hp),
    .p2_hp      (p2_hp),
    .last_player(last_player),
    .winner     (winner)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  int m_sq, m_fq, m_stq, m_cnt;
  int m_hp1, m_hp2, m_last, m_win;
  int m_pd1, m_pd2;
  logic [3:0] d_ns;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_sq = 1; m_fq = 1; m_stq = 0; m_cnt = 0;
    m_hp1 = 0; m_hp2 = 0; m_last = 0; m_win = 0;
    m_pd1 = 0; m_pd2 = 0;
  endfunction

  function automatic int other_turn();
    return (m_last != 0) ? 1 : 2;
  endfunction

  function automatic int model_ns();
    int  s;
    bit  tk, sr, fr;
    s  = int'(state);
    tk = frame_tick && (s == m_stq);
    sr = start_key && (m_sq == 0);
    fr = fire_key && (m_fq == 0);
    case (s)
      0:  return sr ? 15 : 0;
      15: return sr ? 1 : 15;
      1, 2: return (fr || (tk && m_cnt == TF - 1)) ? 3 : s;
      3: begin
        if (!(tk && m_cnt == SF - 1)) return 3;
        if (m_hp1 == 0 || m_hp2 == 0) return 6;
        if (m_pd1 != 0) return 4;
        if (m_pd2 != 0) return 5;
        return other_turn();
      end
      4, 5: return (tk && m_cnt == DF - 1) ? other_turn() : s;
      6:  return sr ? 0 : 6;
      default: return 0;
    endcase
  endfunction

  task automatic tick(input bit ft, input bit h1, input bit h2);
    int ns, s;
    bit chg, exp_s;
    frame_tick = ft;
    hit_p1 = h1;
    hit_p2 = h2;
    @(negedge Clk);
    ns = model_ns();
    d_ns = next_state;
    chk("next_state", next_state, ns);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("p1_hp", p1_hp, m_hp1);
    chk("p2_hp", p2_hp, m_hp2);
    chk("last_player", last_player, m_last);
    chk("winner", winner, m_win);
    @(posedge Clk);
    s = int'(state);
    chg = (s != m_stq);
    exp_s = (s == 3) && ft && !chg && (m_cnt == SF - 1);
    if (s == 15 && ns == 1) begin
      m_hp1 = MH; m_hp2 = MH; m_win = 0; m_last = 0;
    end
    if ((s == 1 || s == 2) && ns == 3) m_last = (s == 2) ? 1 : 0;
    if (s == 3 && ns == 6)
      m_win = (m_hp1 == 0 && m_hp2 == 0) ? 3 : (m_hp1 > 0) ? 1 : 2;
    if (chg) begin m_pd1 = 0; m_pd2 = 0; end
    if (s == 3 && !exp_s) begin
      if (h1) begin m_pd1 = 1; if (m_hp1 > 0) m_hp1--; end
      if (h2) begin m_pd2 = 1; if (m_hp2 > 0) m_hp2--; end
    end
    if (chg) m_cnt = 0;
    else if (ft && m_cnt < 1023) m_cnt++;
    m_sq = start_key ? 1 : 0;
    m_fq = fire_key ? 1 : 0;
    m_stq = s;
    #1 state = 4'(ns);
  endtask

  task automatic release_reset();
    frame_tick = 0; hit_p1 = 0; hit_p2 = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    m_sq = start_key ? 1 : 0;
    m_fq = fire_key ? 1 : 0;
    #1;
  endtask

  task automatic fire();
    fire_key = 1; tick(0, 0, 0);
    fire_key = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0);
  endtask

  initial begin
    m_reset();
    start_key = 1;
    #12;
    chk("rst_next_state", next_state, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_hp", {p1_hp, p2_hp}, 0);
    chk("rst_last_win", {last_player, winner}, 0);
    release_reset();

    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("held_start", d_ns, 0);
    start_key = 0; tick(0, 0, 0);
    start_key = 1; tick(0, 0, 0);
    chk("to_menu", d_ns, 4'hF);
    start_key = 0; tick(0, 0, 0);
    start_key = 1; tick(0, 0, 0);
    chk("game_start", d_ns, 1);
    chk("hp_load", {p1_hp, p2_hp}, {4'd2, 4'd2});
    start_key = 0;

    tick(0, 0, 0);
    ticks(3);
    chk("turn_wait", d_ns, 1);
    tick(1, 0, 0);
    chk("turn_timeout", d_ns, 3);
    tick(0, 0, 0);
    ticks(2);
    tick(1, 0, 0);
    chk("sleep_to_p2", d_ns, 2);

    tick(0, 0, 0);
    fire();
    chk("p2_fire", d_ns, 3);
    chk("last_p2", last_player, 1);
    tick(0, 0, 0);
    ticks(3);
    chk("sleep_to_p1", d_ns, 1);

    tick(0, 0, 0);
    ticks(3);
    fire_key = 1; tick(1, 0, 0);
    fire_key = 0;
    chk("fire_and_timeout", d_ns, 3);
    chk("last_p1", last_player, 0);
    tick(0, 0, 0);
    chk("single_move", d_ns, 3);
    tick(0, 0, 1);
    chk("p2_hit", p2_hp, 1);
    ticks(3);
    chk("to_p2down", d_ns, 5);
    tick(0, 0, 0);
    ticks(2);
    chk("down_to_p2", d_ns, 2);

    tick(0, 0, 0);
    fire();
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("p1_hit", p1_hp, 1);
    ticks(3);
    chk("to_p1down", d_ns, 4);
    tick(0, 0, 0);
    ticks(2);
    chk("down_to_p1", d_ns, 1);

    tick(0, 0, 0);
    fire();
    tick(0, 0, 0);
    tick(0, 1, 1);
    chk("both_hit", {p1_hp, p2_hp}, 0);
    ticks(3);
    chk("to_endgame", d_ns, 6);
    chk("draw", winner, 3);
    tick(0, 0, 0);
    start_key = 1; tick(0, 0, 0);
    start_key = 0;
    chk("end_to_idle", d_ns, 0);
    chk("winner_hold", winner, 3);

    tick(0, 0, 0);
    start_key = 1; tick(0, 0, 0);
    start_key = 0; tick(0, 0, 0);
    start_key = 1; tick(0, 0, 0);
    start_key = 0;
    chk("win_clear", winner, 0);
    tick(0, 0, 0);
    tick(0, 1, 1);
    chk("hit_in_turn", {p1_hp, p2_hp}, {4'd2, 4'd2});
    fire();
    tick(0, 0, 0);
    ticks(2);
    tick(1, 1, 1);
    chk("expiry_no_hit_ns", d_ns, 2);
    chk("hit_at_expiry", {p1_hp, p2_hp}, {4'd2, 4'd2});

    #2 Reset_n = 1'b0;
    #1;
    state = 4'h0;
    m_reset();
    chk("mid_rst_hp", {p1_hp, p2_hp}, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_last", last_player, 0);
    release_reset();

    ticks(1030);
    chk("cnt_saturate", frame_cnt, 1023);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) start_key = ~start_key;
      if ($urandom_range(3) == 0) fire_key = ~fire_key;
      if ($urandom_range(63) == 0) state = 4'($urandom);
      tick(1'($urandom_range(1)),
           $urandom_range(5) == 0,
           $urandom_range(5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
